wts_tone_generator_nch: RTL and testbench

Parametrised, time-multiplexed wave-table tone generator, successor to the fixed 5-channel generator. It owns the channel slot sequencer and all per-channel phase state for NUM_CH channels, and emits one registered wave-table address per clock slot to the wave memory read stage. Over the fixed-channel design it adds per-channel key-on (address restart) and per-channel one-shot mode with end-of-wave status.

---
 rtl/wts_pkg.sv | 42 ++++
 rtl/wts_tone_channel_step.sv | 71 +++++++
 rtl/wts_tone_generator_nch.sv | 170 +++++++++++++++++
 tb/tb_wts_tone_generator_nch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wts_pkg.sv
// -----------------------------------------------------------------------------
// wts_pkg
// Shared definitions for the wave-table tone generator family.
//   - wave_len_e : per-channel wave length code (2 bits)
//   - SLOT_W     : width of the slot counter / out_channel field
//   - MAX_CH     : largest supported channel count
//   - step_size  : address increment for a length code at a given table width
// -----------------------------------------------------------------------------
package wts_pkg;

    // Wave length codes. The whole table is always 2^ADDR_W samples; the code
    // picks how coarsely it is walked, so a shorter wave plays fewer samples.
    typedef enum logic [1:0] {
        LEN_QUARTER  = 2'd0,  // step 4 -> 2^(ADDR_W-2) samples per wave
        LEN_HALF     = 2'd1,  // step 2 -> 2^(ADDR_W-1) samples per wave
        LEN_FULL     = 2'd2,  // step 1 -> 2^ADDR_W samples per wave
        LEN_FULL_ALT = 2'd3   // alias of LEN_FULL
    } wave_len_e;

    localparam int SLOT_W = 4;
    localparam int MAX_CH = 16;

    // Address step for a length code. For very small tables the step is
    // limited to half the table so a wave never collapses onto a single sample.
    function automatic int unsigned step_size(input wave_len_e code,
                                              input int unsigned addr_w);
        int unsigned nominal;
        int unsigned limit;
        case (code)
            LEN_QUARTER: nominal = 4;
            LEN_HALF:    nominal = 2;
            default:     nominal = 1;
        endcase
        if (addr_w >= 2) begin
            limit = 32'd1 << (addr_w - 32'd1);
        end else begin
            limit = 1;
        end
        return (nominal > limit) ? limit : nominal;
    endfunction

endpackage : wts_pkg

// File: rtl/wts_tone_channel_step.sv
// -----------------------------------------------------------------------------
// wts_tone_channel_step
// Combinational next-state for one tone channel. The top level muxes the
// state of the channel owned by the current slot into this block and writes
// the result back, so a single instance serves every channel.
//
// Ports
//   addr_i    [ADDR_W] current wave address
//   cnt_i     [FREQ_W] current divider count
//   end_i              one-shot finished flag
//   kon_i              key-on (direct pulse or pending) for this channel
//   length_i  [2]      wave length code
//   freq_i    [FREQ_W] divider reload value
//   oneshot_i          stop at end of wave instead of wrapping
//   addr_o    [ADDR_W] next wave address
//   cnt_o     [FREQ_W] next divider count
//   end_o              next end flag
// -----------------------------------------------------------------------------
module wts_tone_channel_step
    import wts_pkg::*;
#(
    parameter int FREQ_W = 12,
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [FREQ_W-1:0] cnt_i,
    input  logic              end_i,
    input  logic              kon_i,
    input  logic [1:0]        length_i,
    input  logic [FREQ_W-1:0] freq_i,
    input  logic              oneshot_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [FREQ_W-1:0] cnt_o,
    output logic              end_o
);

    logic [ADDR_W:0] step_w;
    logic [ADDR_W:0] sum_w;

    // One extra bit on the sum so the top bit flags "ran past the table end",
    // which is exactly the one-shot stop condition.
    always_comb begin
        step_w = (ADDR_W + 1)'(step_size(wave_len_e'(length_i), ADDR_W));
        sum_w  = {1'b0, addr_i} + step_w;
    end

    // Priority: key-on, then finished one-shot hold, then divider, then step.
    always_comb begin
        addr_o = addr_i;
        cnt_o  = cnt_i;
        end_o  = end_i;
        if (kon_i) begin
            addr_o = '0;
            cnt_o  = freq_i;
            end_o  = 1'b0;
        end else if (end_i) begin
            // finished one-shot: everything frozen until the next key-on
        end else if (cnt_i != '0) begin
            cnt_o = cnt_i - FREQ_W'(1);
        end else begin
            cnt_o = freq_i;
            if (oneshot_i && sum_w[ADDR_W]) begin
                // last sample stays on the output instead of wrapping to 0
                end_o = 1'b1;
            end else begin
                addr_o = sum_w[ADDR_W-1:0];
            end
        end
    end

endmodule : wts_tone_channel_step

// File: rtl/wts_tone_generator_nch.sv
// -----------------------------------------------------------------------------
// wts_tone_generator_nch
// Time-multiplexed wave-table tone generator for NUM_CH channels. A slot
// counter visits one channel per enabled clock; the visited channel's phase
// state is updated and its new wave address is registered out for the wave
// memory read stage.
//
// Output handshake: out_valid is a plain qualifier with no back-pressure.
// out_valid=1 means out_channel/wave_address describe the slot processed on
// the previous edge; the consumer must take it that cycle. When out_valid=0
// the address fields keep their last values and must be ignored.
//
// Ports
//   clk                  system clock
//   nreset               asynchronous active-low reset
//   enable               slot advance strobe; 0 freezes sequencer and state
//   reg_wave_length      [2*NUM_CH]      length code, channel c at [2c+1:2c]
//   reg_frequency_count  [FREQ_W*NUM_CH] divider reload, channel c at [FREQ_W*c +: FREQ_W]
//   reg_oneshot          [NUM_CH]        1 = stop at end of wave
//   key_on               [NUM_CH]        one-clock restart pulse per channel
//   out_valid                            output qualifier
//   out_channel          [4]             channel index of current output
//   wave_address         [ADDR_W]        sample address for out_channel
//   channel_end          [NUM_CH]        sticky one-shot finished flags
// -----------------------------------------------------------------------------
module wts_tone_generator_nch
    import wts_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int FREQ_W = 12,
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     enable,
    input  logic [2*NUM_CH-1:0]      reg_wave_length,
    input  logic [FREQ_W*NUM_CH-1:0] reg_frequency_count,
    input  logic [NUM_CH-1:0]        reg_oneshot,
    input  logic [NUM_CH-1:0]        key_on,
    output logic                     out_valid,
    output logic [SLOT_W-1:0]        out_channel,
    output logic [ADDR_W-1:0]        wave_address,
    output logic [NUM_CH-1:0]        channel_end
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    // ---------------------------------------------------------------- state
    logic [SLOT_W-1:0]             slot_q, slot_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_CH-1:0][FREQ_W-1:0] cnt_q,  cnt_d;
    logic [NUM_CH-1:0]             end_q,  end_d;
    logic [NUM_CH-1:0]             kon_q,  kon_d;

    logic                          out_valid_q,    out_valid_d;
    logic [SLOT_W-1:0]             out_channel_q,  out_channel_d;
    logic [ADDR_W-1:0]             wave_address_q, wave_address_d;

    // ------------------------------------------------- selected slot inputs
    logic [ADDR_W-1:0] sel_addr;
    logic [FREQ_W-1:0] sel_cnt;
    logic              sel_end;
    logic              sel_kon;
    logic [1:0]        sel_len;
    logic [FREQ_W-1:0] sel_freq;
    logic              sel_oneshot;

    logic [ADDR_W-1:0] nxt_addr;
    logic [FREQ_W-1:0] nxt_cnt;
    logic              nxt_end;

    // Equality-compare mux rather than a variable index: the slot counter is
    // wider than the channel index for most NUM_CH values.
    always_comb begin
        sel_addr    = '0;
        sel_cnt     = '0;
        sel_end     = 1'b0;
        sel_kon     = 1'b0;
        sel_len     = '0;
        sel_freq    = '0;
        sel_oneshot = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q == SLOT_W'(c)) begin
                sel_addr    = addr_q[c];
                sel_cnt     = cnt_q[c];
                sel_end     = end_q[c];
                // a pulse arriving on the channel's own slot is applied now
                sel_kon     = key_on[c] | kon_q[c];
                sel_len     = reg_wave_length[2*c +: 2];
                sel_freq    = reg_frequency_count[FREQ_W*c +: FREQ_W];
                sel_oneshot = reg_oneshot[c];
            end
        end
    end

    wts_tone_channel_step #(
        .FREQ_W (FREQ_W),
        .ADDR_W (ADDR_W)
    ) u_step (
        .addr_i    (sel_addr),
        .cnt_i     (sel_cnt),
        .end_i     (sel_end),
        .kon_i     (sel_kon),
        .length_i  (sel_len),
        .freq_i    (sel_freq),
        .oneshot_i (sel_oneshot),
        .addr_o    (nxt_addr),
        .cnt_o     (nxt_cnt),
        .end_o     (nxt_end)
    );

    // --------------------------------------------------------- next state
    always_comb begin
        slot_d         = slot_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        end_d          = end_q;
        // Key-ons for channels not being processed (or any key-on while
        // frozen) are remembered until that channel's next visit.
        kon_d          = kon_q | key_on;
        out_valid_d    = enable;
        out_channel_d  = out_channel_q;
        wave_address_d = wave_address_q;

        if (enable) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (slot_q == SLOT_W'(c)) begin
                    addr_d[c] = nxt_addr;
                    cnt_d[c]  = nxt_cnt;
                    end_d[c]  = nxt_end;
                    kon_d[c]  = 1'b0;
                end
            end
            out_channel_d  = slot_q;
            wave_address_d = nxt_addr;
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_q         <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            end_q          <= '0;
            kon_q          <= '0;
            out_valid_q    <= 1'b0;
            out_channel_q  <= '0;
            wave_address_q <= '0;
        end else begin
            slot_q         <= slot_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            end_q          <= end_d;
            kon_q          <= kon_d;
            out_valid_q    <= out_valid_d;
            out_channel_q  <= out_channel_d;
            wave_address_q <= wave_address_d;
        end
    end

    // end_q is updated on the same edge as the output registers, so a
    // channel_end bit rises together with the output that finished it.
    assign out_valid    = out_valid_q;
    assign out_channel  = out_channel_q;
    assign wave_address = wave_address_q;
    assign channel_end  = end_q;

endmodule : wts_tone_generator_nch

// File: tb/tb_wts_tone_generator_nch.sv
module tb_wts_tone_generator_nch;

    localparam int NUM_CH = 5;
    localparam int FREQ_W = 12;
    localparam int ADDR_W = 7;
    localparam int W      = 4 + ADDR_W + NUM_CH;

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic                     enable;
    logic [2*NUM_CH-1:0]      reg_wave_length;
    logic [FREQ_W*NUM_CH-1:0] reg_frequency_count;
    logic [NUM_CH-1:0]        reg_oneshot;
    logic [NUM_CH-1:0]        key_on;
    logic                     out_valid;
    logic [3:0]               out_channel;
    logic [ADDR_W-1:0]        wave_address;
    logic [NUM_CH-1:0]        channel_end;

    wts_tone_generator_nch #(
        .NUM_CH (NUM_CH),
        .FREQ_W (FREQ_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .enable              (enable),
        .reg_wave_length     (reg_wave_length),
        .reg_frequency_count (reg_frequency_count),
        .reg_oneshot         (reg_oneshot),
        .key_on              (key_on),
        .out_valid           (out_valid),
        .out_channel         (out_channel),
        .wave_address        (wave_address),
        .channel_end         (channel_end)
    );

    // ------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    // bench-side configuration and reference state
    int cfg_len  [NUM_CH];
    int cfg_freq [NUM_CH];
    bit cfg_os   [NUM_CH];

    int m_addr [NUM_CH];
    int m_cnt  [NUM_CH];
    bit m_end  [NUM_CH];
    bit m_kp   [NUM_CH];
    int m_slot;
    logic [3:0]        last_ch;
    logic [ADDR_W-1:0] last_addr;

    bit track_wrap = 1'b0;
    int prev_ch0   = -1;
    int wraps_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input int len, input int freq, input bit os);
        cfg_len[c]  = len;
        cfg_freq[c] = freq;
        cfg_os[c]   = os;
        reg_wave_length[2*c +: 2]               = 2'(len);
        reg_frequency_count[FREQ_W*c +: FREQ_W] = FREQ_W'(freq);
        reg_oneshot[c]                          = os;
    endtask

    function automatic logic [NUM_CH-1:0] m_endvec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_end[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_addr[c] = 0;
            m_cnt[c]  = 0;
            m_end[c]  = 1'b0;
            m_kp[c]   = 1'b0;
        end
        m_slot    = 0;
        last_ch   = '0;
        last_addr = '0;
        exp_q.delete();
    endtask

    // Reference behaviour of one clock edge; pushes the expected output.
    task automatic model_step(input bit en, input logic [NUM_CH-1:0] kon);
        int s;
        int st;
        if (!en) begin
            for (int c = 0; c < NUM_CH; c++) if (kon[c]) m_kp[c] = 1'b1;
            return;
        end
        s = m_slot;
        for (int c = 0; c < NUM_CH; c++) if (c != s && kon[c]) m_kp[c] = 1'b1;
        if (kon[s] || m_kp[s]) begin
            m_addr[s] = 0;
            m_cnt[s]  = cfg_freq[s];
            m_end[s]  = 1'b0;
            m_kp[s]   = 1'b0;
        end else if (m_end[s]) begin
            // frozen
        end else if (m_cnt[s] != 0) begin
            m_cnt[s] = m_cnt[s] - 1;
        end else begin
            m_cnt[s] = cfg_freq[s];
            st = (cfg_len[s] == 0) ? 4 : (cfg_len[s] == 1) ? 2 : 1;
            if (cfg_os[s] && (m_addr[s] + st >= (1 << ADDR_W))) m_end[s] = 1'b1;
            else m_addr[s] = (m_addr[s] + st) % (1 << ADDR_W);
        end
        last_ch   = 4'(s);
        last_addr = ADDR_W'(m_addr[s]);
        exp_q.push_back({4'(s), ADDR_W'(m_addr[s]), m_endvec()});
        m_slot = (s + 1) % NUM_CH;
    endtask

    // ------------------------------------------------------ driver task
    task automatic drive(input bit en, input logic [NUM_CH-1:0] kon);
        logic [W-1:0] e;
        enable = en;
        key_on = kon;
        model_step(en, kon);
        @(posedge clk);
        #1;
        key_on = '0;
        if (en) begin
            e = exp_q.pop_front();
            chk("out_valid_high", 32'(out_valid), 32'd1);
            chk("chan_addr_end", 32'({out_channel, wave_address, channel_end}), 32'(e));
            if (track_wrap && out_channel == 4'd0) begin
                if (prev_ch0 == 127) begin
                    chk("ch0_wrap_to_0", 32'(wave_address), 32'd0);
                    wraps_seen++;
                end
                prev_ch0 = int'(wave_address);
            end
        end else begin
            chk("out_valid_low", 32'(out_valid), 32'd0);
            chk("gap_hold", 32'({out_channel, wave_address}), 32'({last_ch, last_addr}));
            chk("gap_end_hold", 32'(channel_end), 32'(m_endvec()));
        end
    endtask

    task automatic drive_to_slot(input int target);
        for (int k = 0; k < NUM_CH && m_slot != target; k++) drive(1'b1, '0);
    endtask

    // ------------------------------------------------------ vector table
    typedef struct {
        bit                en;
        logic [NUM_CH-1:0] kon;
        bit                valid;
        logic [3:0]        ch;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t tbl[17];

    int div_seq[$];
    int div_exp[9] = '{0, 0, 0, 0, 4, 4, 4, 4, 8};
    bit os_seen;
    int n1;

    // ------------------------------------------------------ test body
    initial begin
        nreset = 1'b0;
        enable = 1'b0;
        key_on = '0;
        reg_wave_length     = '0;
        reg_frequency_count = '0;
        reg_oneshot         = '0;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 2, 0, 1'b0);
        set_ch(2, 0, 3, 1'b0);
        model_reset();

        // key-on everything, run, gap with key_on[1], key_on[3] on its own slot
        tbl[0]  = '{1'b1, 5'b11111, 1'b1, 4'd0, 7'd0};
        tbl[1]  = '{1'b1, 5'b00000, 1'b1, 4'd1, 7'd0};
        tbl[2]  = '{1'b1, 5'b00000, 1'b1, 4'd2, 7'd0};
        tbl[3]  = '{1'b1, 5'b00000, 1'b1, 4'd3, 7'd0};
        tbl[4]  = '{1'b1, 5'b00000, 1'b1, 4'd4, 7'd0};
        tbl[5]  = '{1'b1, 5'b00000, 1'b1, 4'd0, 7'd1};
        tbl[6]  = '{1'b0, 5'b00000, 1'b0, 4'd0, 7'd1};
        tbl[7]  = '{1'b0, 5'b00010, 1'b0, 4'd0, 7'd1};
        tbl[8]  = '{1'b1, 5'b00000, 1'b1, 4'd1, 7'd0};
        tbl[9]  = '{1'b1, 5'b00000, 1'b1, 4'd2, 7'd0};
        tbl[10] = '{1'b1, 5'b00000, 1'b1, 4'd3, 7'd1};
        tbl[11] = '{1'b1, 5'b00000, 1'b1, 4'd4, 7'd1};
        tbl[12] = '{1'b1, 5'b00000, 1'b1, 4'd0, 7'd2};
        tbl[13] = '{1'b1, 5'b00000, 1'b1, 4'd1, 7'd1};
        tbl[14] = '{1'b1, 5'b00000, 1'b1, 4'd2, 7'd0};
        tbl[15] = '{1'b1, 5'b01000, 1'b1, 4'd3, 7'd0};
        tbl[16] = '{1'b1, 5'b00000, 1'b1, 4'd4, 7'd2};

        // reset values
        #22;
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_out_channel",  32'(out_channel),  32'd0);
        chk("rst_wave_address", 32'(wave_address), 32'd0);
        chk("rst_channel_end",  32'(channel_end),  32'd0);
        @(negedge clk);
        nreset = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].en, tbl[i].kon);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid),    32'(tbl[i].valid));
            chk($sformatf("tbl%0d_chan", i),  32'(out_channel),  32'(tbl[i].ch));
            chk($sformatf("tbl%0d_addr", i),  32'(wave_address), 32'(tbl[i].addr));
        end

        // long free run: channel 0 wraps 127 -> 0
        track_wrap = 1'b1;
        prev_ch0   = -1;
        for (int i = 0; i < 700; i++) drive(1'b1, '0);
        track_wrap = 1'b0;
        chk("ch0_wrap_observed", 32'(wraps_seen > 0), 32'd1);

        // divider: channel 2, freq 3, length 0, after key-on on its own slot
        drive_to_slot(2);
        drive(1'b1, 5'b00100);
        div_seq.push_back(int'(wave_address));
        for (int i = 0; i < 45 && div_seq.size() < 9; i++) begin
            drive(1'b1, '0);
            if (out_channel == 4'd2) div_seq.push_back(int'(wave_address));
        end
        chk("div_seq_len", 32'(div_seq.size()), 32'd9);
        for (int i = 0; i < 9 && i < div_seq.size(); i++)
            chk($sformatf("div_seq%0d", i), 32'(div_seq[i]), 32'(div_exp[i]));

        // one-shot: channel 1, length 0, freq 0
        set_ch(1, 0, 0, 1'b1);
        drive_to_slot(1);
        drive(1'b1, 5'b00010);
        n1 = 1;
        os_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, '0);
            if (out_channel == 4'd1) begin
                n1++;
                if (channel_end[1] && !os_seen) begin
                    os_seen = 1'b1;
                    chk("os_end_addr", 32'(wave_address), 32'd124);
                    chk("os_end_visit", 32'(n1), 32'd33);
                end
            end
        end
        chk("os_end_seen", 32'(os_seen), 32'd1);
        drive_to_slot(1);
        drive(1'b1, '0);
        chk("os_held_addr", 32'(wave_address), 32'd124);
        chk("os_held_end", 32'(channel_end[1]), 32'd1);

        // key-on while slot 3 after channel 1 ended -> applied at next ch1 visit
        drive_to_slot(3);
        drive(1'b1, 5'b00010);
        for (int k = 0; k < NUM_CH && m_slot != 2; k++) drive(1'b1, '0);
        chk("kon_s3_chan", 32'(out_channel), 32'd1);
        chk("kon_s3_addr", 32'(wave_address), 32'd0);
        chk("kon_s3_end",  32'(channel_end[1]), 32'd0);
        drive_to_slot(1);
        drive(1'b1, '0);
        chk("after_kon_addr", 32'(wave_address), 32'd4);
        // key-on on channel 1's own slot
        drive_to_slot(1);
        drive(1'b1, 5'b00010);
        chk("kon_s1_chan", 32'(out_channel), 32'd1);
        chk("kon_s1_addr", 32'(wave_address), 32'd0);

        // run channel 1 to its end again, then clear oneshot: end stays
        for (int i = 0; i < 200; i++) drive(1'b1, '0);
        set_ch(1, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, '0);
        chk("end_sticky_after_os_clear", 32'(channel_end[1]), 32'd1);

        // async reset mid-run with a key-on pending on channel 4
        set_ch(4, 2, 2, 1'b0);
        drive_to_slot(0);
        drive(1'b1, 5'b10000);
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        chk("arst_out_valid",    32'(out_valid),    32'd0);
        chk("arst_out_channel",  32'(out_channel),  32'd0);
        chk("arst_wave_address", 32'(wave_address), 32'd0);
        chk("arst_channel_end",  32'(channel_end),  32'd0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        drive(1'b1, '0);
        chk("post_rst_chan", 32'(out_channel), 32'd0);
        chk("post_rst_addr", 32'(wave_address), 32'd1);
        for (int i = 0; i < 9; i++) drive(1'b1, '0);

        // random enables, key-ons and configuration changes
        for (int i = 0; i < 600; i++) begin
            logic [NUM_CH-1:0] kon;
            kon = '0;
            if ($urandom_range(0, 7) == 0) kon[$urandom_range(0, NUM_CH - 1)] = 1'b1;
            if ($urandom_range(0, 15) == 0)
                set_ch($urandom_range(0, NUM_CH - 1), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            drive($urandom_range(0, 3) != 0, kon);
        end

        enable = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_wts_tone_generator_nch
